// File: rtl/disp_pkg.sv
// Shared constants and encodings for the display scheduler slice.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package disp_pkg;

    // Segment words are active-low, one byte per digit {dp,g,f,e,d,c,b,a}, digit 3 in the MSBs.
    localparam logic [31:0] SEG_BLANK = 32'hFFFF_FFFF;
    // "Err " : E = 8'h86, r = 8'hAF, blank = 8'hFF
    localparam logic [31:0] SEG_ERR   = 32'h86AF_AFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    typedef enum logic {
        SRC_RESULT = 1'b0,
        SRC_ENTRY  = 1'b1
    } src_t;

endpackage

// File: rtl/display_scheduler_if.sv
// Bundle of source handshakes and display_out frame signals around the scheduler.
// Latency: n/a (wires only).
// Backpressure: sources hold req until ack; frames are paced by sending_data.
interface display_scheduler_if;
    logic        entry_req;
    logic [15:0] entry_bcd;
    logic        entry_ack;
    logic        result_req;
    logic [15:0] result_bcd;
    logic        result_err;
    logic        result_ack;
    logic        disp_start;
    logic [15:0] disp_bcd;
    logic [31:0] disp_seg;
    logic        disp_raw;
    logic        sending_data;
    logic        frame_done;
    logic        timeout_err;

    // Scheduler side
    modport master (
        input  entry_req, entry_bcd, result_req, result_bcd, result_err, sending_data,
        output entry_ack, result_ack, disp_start, disp_bcd, disp_seg, disp_raw,
               frame_done, timeout_err
    );

    // Sources and display_out side
    modport slave (
        output entry_req, entry_bcd, result_req, result_bcd, result_err, sending_data,
        input  entry_ack, result_ack, disp_start, disp_bcd, disp_seg, disp_raw,
               frame_done, timeout_err
    );
endinterface

// File: rtl/disp_rr_arbiter.sv
// Two-requester round-robin arbiter: picks result or entry, pulses the winner's ack.
// Latency: combinational grant/ack while grant_en is high; pointer updates on that edge.
// Backpressure: requesters hold req until their ack; losers simply stay pending.
module disp_rr_arbiter
    import disp_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic grant_en,
    input  logic result_req,
    input  logic entry_req,
    output logic result_ack,
    output logic entry_ack,
    output logic grant_vld,
    output src_t grant_src
);

    logic rr_ptr;   // 0 = result preferred on contention, 1 = entry preferred
    logic both_req;

    // Winner selection; the pointer only matters when both sources contend
    always_comb begin
        both_req  = result_req & entry_req;
        grant_vld = result_req | entry_req;
        if (both_req) begin
            grant_src = rr_ptr ? SRC_ENTRY : SRC_RESULT;
        end else if (entry_req) begin
            grant_src = SRC_ENTRY;
        end else begin
            grant_src = SRC_RESULT;
        end
        result_ack = grant_en & grant_vld & (grant_src == SRC_RESULT);
        entry_ack  = grant_en & grant_vld & (grant_src == SRC_ENTRY);
    end

    // Flip preference after a contended grant so the loser wins next time
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (grant_en && both_req) begin
            rr_ptr <= ~rr_ptr;
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Schedules display_out frames: arbitrates entry/result updates, refreshes, blinks errors, guards timeouts.
// Latency: req -> ack 1 cycle, ack -> disp_start 1 cycle; refresh every REFRESH_CYCLES idle cycles.
// Backpressure: one frame in flight; requests stay pending until the FSM returns to IDLE.
module display_scheduler
    import disp_pkg::*;
#(
    parameter int REFRESH_CYCLES = 50000,
    parameter int BLINK_FRAMES   = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int START_WINDOW   = 2
)
(
    input  logic clk,
    input  logic reset,
    display_scheduler_if.master bus
);

    localparam int RW = $clog2(REFRESH_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + START_WINDOW + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] WINDOW_LAST  = TW'(START_WINDOW - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_FRAMES - 1);

    state_t          state, state_nxt;
    logic            grant_en, start_frame, done_ok, abort;
    logic [RW-1:0]   refresh_cnt;
    logic [TW-1:0]   tmr;
    logic [15:0]     shadow;
    logic            err_latched, blink_phase;
    logic [BW-1:0]   blink_cnt;
    logic            frame_done_q, timeout_err_q;
    logic            grant_vld, result_ack, entry_ack;
    src_t            grant_src;

    disp_rr_arbiter u_arb (
        .clk        (clk),
        .reset      (reset),
        .grant_en   (grant_en),
        .result_req (bus.result_req),
        .entry_req  (bus.entry_req),
        .result_ack (result_ack),
        .entry_ack  (entry_ack),
        .grant_vld  (grant_vld),
        .grant_src  (grant_src)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state strobes; updates win over refresh, waits are bounded
    always_comb begin
        state_nxt   = state;
        grant_en    = 1'b0;
        start_frame = 1'b0;
        done_ok     = 1'b0;
        abort       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_nxt = ST_GRANT;
                end else if (refresh_cnt == REFRESH_LAST) begin
                    state_nxt = ST_START;
                end
            end
            ST_GRANT: begin
                grant_en  = 1'b1;
                state_nxt = ST_START;
            end
            ST_START: begin
                start_frame = 1'b1;
                state_nxt   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.sending_data) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (tmr == WINDOW_LAST) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.sending_data) begin
                    done_ok   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmr == TIMEOUT_LAST) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Refresh counter: starts at terminal so the first frame goes out right after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= REFRESH_LAST;
        end else if (state_nxt == ST_START) begin
            refresh_cnt <= '0;
        end else if (state == ST_IDLE && refresh_cnt != REFRESH_LAST) begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // Wait timer shared by WAIT_BUSY and WAIT_DONE, restarted on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr <= '0;
        end else if (state_nxt != state) begin
            tmr <= '0;
        end else if (state == ST_WAIT_BUSY || state == ST_WAIT_DONE) begin
            tmr <= tmr + 1'b1;
        end
    end

    // Shadow, error latch and blink state; shadow only moves in GRANT so frames stay stable
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow      <= 16'h0000;
            err_latched <= 1'b0;
            blink_phase <= 1'b1;
            blink_cnt   <= '0;
        end else if (grant_en && grant_vld) begin
            if (grant_src == SRC_ENTRY) begin
                shadow      <= bus.entry_bcd;
                err_latched <= 1'b0;
            end else begin
                shadow      <= bus.result_bcd;
                err_latched <= bus.result_err;
                if (bus.result_err && !err_latched) begin
                    blink_phase <= 1'b1;
                    blink_cnt   <= '0;
                end
            end
        end else if (done_ok && err_latched) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Completion pulse one cycle after busy drops; timeout flag is sticky until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            frame_done_q <= done_ok;
            if (abort) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign bus.entry_ack   = entry_ack;
    assign bus.result_ack  = result_ack;
    assign bus.disp_start  = start_frame;
    assign bus.disp_bcd    = shadow;
    assign bus.disp_raw    = err_latched;
    assign bus.disp_seg    = (err_latched && blink_phase) ? SEG_ERR : SEG_BLANK;
    assign bus.frame_done  = frame_done_q;
    assign bus.timeout_err = timeout_err_q;

endmodule
